// File: rtl/sdsp_weight_rmw.sv
// SDSP weight read-modify-write engine: reads a 32-bit synapse word, nudges one
// 3-bit weight up or down with saturation, and writes the word back only when it changed.
module sdsp_weight_rmw #(
    parameter int ADDR_W = 13
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [2:0]        REQ_SLOT,
    input  logic              REQ_V_UP,
    input  logic              REQ_V_DOWN,
    output logic              SRAM_CS,
    output logic              SRAM_WE,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [31:0]       SRAM_WDATA,
    input  logic [31:0]       SRAM_RDATA,
    output logic              DONE,
    output logic [2:0]        WEIGHT_OUT,
    output logic              UPDATED
);

    // Handshake: a request transfers on a rising edge where REQ_VALID and REQ_READY
    // are both high; REQ_READY is high only in IDLE and requests seen while busy are dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]        slot_q;
    logic              v_up_q;
    logic              v_down_q;

    logic [3:0]        syn;
    logic [2:0]        w_cur;
    logic [2:0]        w_new;
    logic              changed;
    logic [31:0]       word_new;

    logic              latch_en;
    logic              cs_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic              done_d;
    logic [2:0]        weight_d;
    logic              updated_d;

    assign REQ_READY = (state == IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ_VALID) state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = WR;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Weight update on the word being returned this cycle; only used while in CAP.
    always_comb begin
        syn      = SRAM_RDATA[{slot_q, 2'b00} +: 4];
        w_cur    = syn[2:0];
        w_new    = w_cur;
        if (syn[3] && v_up_q && !v_down_q && (w_cur != 3'd7)) begin
            w_new = w_cur + 3'd1;
        end else if (syn[3] && v_down_q && !v_up_q && (w_cur != 3'd0)) begin
            w_new = w_cur - 3'd1;
        end
        changed  = (w_new != w_cur);
        word_new = SRAM_RDATA;
        word_new[{slot_q, 2'b00} +: 3] = w_new;
    end

    always_comb begin
        latch_en  = 1'b0;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = SRAM_ADDR;
        wdata_d   = SRAM_WDATA;
        done_d    = 1'b0;
        weight_d  = WEIGHT_OUT;
        updated_d = UPDATED;
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    latch_en = 1'b1;
                    cs_d     = 1'b1;
                    addr_d   = REQ_ADDR;
                end
            end
            CAP: begin
                done_d    = 1'b1;
                weight_d  = w_new;
                updated_d = changed;
                if (changed) begin
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = word_new;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_q     <= 3'd0;
            v_up_q     <= 1'b0;
            v_down_q   <= 1'b0;
            SRAM_CS    <= 1'b0;
            SRAM_WE    <= 1'b0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= 32'd0;
            DONE       <= 1'b0;
            WEIGHT_OUT <= 3'd0;
            UPDATED    <= 1'b0;
        end else begin
            if (latch_en) begin
                slot_q   <= REQ_SLOT;
                v_up_q   <= REQ_V_UP;
                v_down_q <= REQ_V_DOWN;
            end
            SRAM_CS    <= cs_d;
            SRAM_WE    <= we_d;
            SRAM_ADDR  <= addr_d;
            SRAM_WDATA <= wdata_d;
            DONE       <= done_d;
            WEIGHT_OUT <= weight_d;
            UPDATED    <= updated_d;
        end
    end

endmodule

// File: tb/tb_sdsp_weight_rmw.sv
// Bench for sdsp_weight_rmw: behavioural SRAM, reference memory model, per-cycle
// expectation queue, directed corner cases followed by randomized traffic.
module tb_sdsp_weight_rmw;

    localparam int ADDR_W = 13;

    logic              CLK = 1'b0;
    logic              RST;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [2:0]        REQ_SLOT;
    logic              REQ_V_UP;
    logic              REQ_V_DOWN;
    logic              SRAM_CS;
    logic              SRAM_WE;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [31:0]       SRAM_WDATA;
    logic [31:0]       SRAM_RDATA;
    logic              DONE;
    logic [2:0]        WEIGHT_OUT;
    logic              UPDATED;

    always #5 CLK = ~CLK;

    sdsp_weight_rmw #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_SLOT(REQ_SLOT), .REQ_V_UP(REQ_V_UP), .REQ_V_DOWN(REQ_V_DOWN),
        .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA),
        .DONE(DONE), .WEIGHT_OUT(WEIGHT_OUT), .UPDATED(UPDATED)
    );

    // Synchronous SRAM: read data appears the cycle after the read is sampled.
    logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem  [0:(1<<ADDR_W)-1];

    always @(posedge CLK) begin
        if (SRAM_CS && !SRAM_WE) SRAM_RDATA <= sram_mem[SRAM_ADDR];
        if (SRAM_CS && SRAM_WE) sram_mem[SRAM_ADDR] = SRAM_WDATA;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Reference model: the outcome of one update straight from the weight rules.
    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  wn;
        logic        upd;
    } res_t;

    function automatic res_t model(input logic [31:0] word, input logic [2:0] s,
                                   input logic up, input logic dn);
        res_t r;
        int sh = 4 * int'(s);
        int w  = int'((word >> sh) & 32'h7);
        int m  = int'((word >> (sh + 3)) & 32'h1);
        int wn = w;
        if (m == 1 && up && !dn && w < 7) wn = w + 1;
        else if (m == 1 && dn && !up && w > 0) wn = w - 1;
        r.word = (word & ~(32'h7 << sh)) | (32'(wn) << sh);
        r.wn   = 3'(wn);
        r.upd  = (wn != w);
        return r;
    endfunction

    // One entry per busy cycle after acceptance (cycles T+1, T+2, T+3).
    typedef struct packed {
        logic              done;
        logic              cs;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [2:0]        weight;
        logic              upd;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur_e;
    bit         chk_en     = 1'b0;
    logic [2:0] exp_weight = 3'd0;
    logic       exp_upd    = 1'b0;

    always @(negedge CLK) begin
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                cur_e = exp_q.pop_front();
                chk("ready_busy", 32'(REQ_READY), 32'd0);
                chk("done", 32'(DONE), 32'(cur_e.done));
                chk("sram_cs", 32'(SRAM_CS), 32'(cur_e.cs));
                chk("sram_we", 32'(SRAM_WE), 32'(cur_e.we));
                if (cur_e.cs) chk("sram_addr", 32'(SRAM_ADDR), 32'(cur_e.addr));
                if (cur_e.we) chk("sram_wdata", SRAM_WDATA, cur_e.wdata);
                if (cur_e.done) begin
                    exp_weight = cur_e.weight;
                    exp_upd    = cur_e.upd;
                end
            end else begin
                chk("ready_idle", 32'(REQ_READY), 32'd1);
                chk("done_idle", 32'(DONE), 32'd0);
                chk("cs_idle", 32'(SRAM_CS), 32'd0);
                chk("we_idle", 32'(SRAM_WE), 32'd0);
            end
            chk("weight_out", 32'(WEIGHT_OUT), 32'(exp_weight));
            chk("updated", 32'(UPDATED), 32'(exp_upd));
        end
    end

    int accept_cyc;

    task automatic send(input logic [ADDR_W-1:0] a, input logic [2:0] s,
                        input logic up, input logic dn, input bit keep);
        res_t r;
        exp_t e;
        int   n;
        @(negedge CLK);
        REQ_ADDR   = a;
        REQ_SLOT   = s;
        REQ_V_UP   = up;
        REQ_V_DOWN = dn;
        REQ_VALID  = 1'b1;
        n = 0;
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            chk("ready_timeout", 32'd0, 32'd1);
            REQ_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        accept_cyc = cyc;
        r = model(ref_mem[a], s, up, dn);
        ref_mem[a] = r.word;
        e = '0;
        e.cs = 1'b1; e.addr = a;
        exp_q.push_back(e);
        e = '0;
        exp_q.push_back(e);
        e.done = 1'b1; e.cs = r.upd; e.we = r.upd; e.addr = a;
        e.wdata = r.word; e.weight = r.wn; e.upd = r.upd;
        exp_q.push_back(e);
        if (!keep) REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        sram_mem[a] = w;
        ref_mem[a]  = w;
    endtask

    int first_acc;
    logic [ADDR_W-1:0] ra;
    logic [1:0]        rc;
    bit                rk;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            sram_mem[i] = 32'd0;
            ref_mem[i]  = 32'd0;
        end
        RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_SLOT = 3'd0;
        REQ_V_UP = 1'b0; REQ_V_DOWN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", 32'(REQ_READY), 32'd1);
        chk("rst_cs", 32'(SRAM_CS), 32'd0);
        chk("rst_we", 32'(SRAM_WE), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_wdata", SRAM_WDATA, 32'd0);
        chk("rst_weight", 32'(WEIGHT_OUT), 32'd0);
        chk("rst_updated", 32'(UPDATED), 32'd0);
        chk_en = 1'b1;

        // Potentiation: slot 2 m=1 w=2 -> 3.
        preload(13'd5, 32'h0000_0A00);
        send(13'd5, 3'd2, 1'b1, 1'b0, 1'b0);
        drain();
        chk("pot_mem", sram_mem[5], 32'h0000_0B00);
        chk("pot_weight", 32'(WEIGHT_OUT), 32'd3);
        chk("pot_updated", 32'(UPDATED), 32'd1);

        // Saturation at the top and bottom.
        preload(13'd6, 32'h0000_000F);
        send(13'd6, 3'd0, 1'b1, 1'b0, 1'b0);
        drain();
        chk("sat_hi_mem", sram_mem[6], 32'h0000_000F);
        chk("sat_hi_weight", 32'(WEIGHT_OUT), 32'd7);
        chk("sat_hi_updated", 32'(UPDATED), 32'd0);
        preload(13'd7, 32'h0000_0008);
        send(13'd7, 3'd0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("sat_lo_weight", 32'(WEIGHT_OUT), 32'd0);
        chk("sat_lo_updated", 32'(UPDATED), 32'd0);

        // Mapping bit clear blocks any change.
        preload(13'd8, 32'h5000_0000);
        send(13'd8, 3'd7, 1'b1, 1'b0, 1'b0);
        drain();
        chk("nomap_mem", sram_mem[8], 32'h5000_0000);
        chk("nomap_weight", 32'(WEIGHT_OUT), 32'd5);

        // Depression on a full word touches only slot 4 weight bits.
        preload(13'd9, 32'hFFFF_FFFF);
        send(13'd9, 3'd4, 1'b0, 1'b1, 1'b0);
        drain();
        chk("dep_mem", sram_mem[9], 32'hFFFE_FFFF);
        chk("dep_weight", 32'(WEIGHT_OUT), 32'd6);

        // UP and DOWN together is treated as no change.
        preload(13'd10, 32'h0000_00A0);
        send(13'd10, 3'd1, 1'b1, 1'b1, 1'b0);
        drain();
        chk("illegal_mem", sram_mem[10], 32'h0000_00A0);
        chk("illegal_weight", 32'(WEIGHT_OUT), 32'd2);
        chk("illegal_updated", 32'(UPDATED), 32'd0);

        // REQ_VALID held: second request accepted four cycles later, coherent.
        preload(13'd11, 32'h0000_0A00);
        send(13'd11, 3'd2, 1'b1, 1'b0, 1'b1);
        first_acc = accept_cyc;
        send(13'd11, 3'd2, 1'b1, 1'b0, 1'b0);
        chk("b2b_spacing", 32'(accept_cyc - first_acc), 32'd4);
        drain();
        chk("b2b_mem", sram_mem[11], 32'h0000_0C00);
        chk("b2b_weight", 32'(WEIGHT_OUT), 32'd4);

        // Reset during the capture cycle aborts the request.
        preload(13'd12, 32'h0000_0A00);
        chk_en = 1'b0;
        @(negedge CLK);
        REQ_ADDR = 13'd12; REQ_SLOT = 3'd2; REQ_V_UP = 1'b1; REQ_V_DOWN = 1'b0;
        REQ_VALID = 1'b1;
        chk("abort_ready", 32'(REQ_READY), 32'd1);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("abort_cs", 32'(SRAM_CS), 32'd0);
            chk("abort_we", 32'(SRAM_WE), 32'd0);
            chk("abort_done", 32'(DONE), 32'd0);
        end
        RST = 1'b0;
        exp_weight = 3'd0;
        exp_upd    = 1'b0;
        @(negedge CLK);
        chk("abort_ready_after", 32'(REQ_READY), 32'd1);
        chk("abort_mem", sram_mem[12], 32'h0000_0A00);
        chk_en = 1'b1;
        repeat (4) @(negedge CLK);

        // Randomized traffic over a small address window to force reuse.
        for (int i = 32; i < 48; i++) preload(13'(i), $urandom);
        for (int i = 0; i < 200; i++) begin
            ra = 13'(32 + $urandom_range(0, 15));
            rc = 2'($urandom_range(0, 3));
            rk = (i != 199) && ($urandom_range(0, 3) == 0);
            send(ra, 3'($urandom_range(0, 7)), rc[0], rc[1], rk);
            if (!rk) repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        drain();
        for (int i = 0; i < 48; i++) chk("final_mem", sram_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
